// File: rtl/cpu_sequencer_pkg.sv
// rtl/cpu_sequencer_pkg.sv - shared state, opcode-class and mem_to_reg encodings
package cpu_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH1,
    FETCH2,
    DECODE,
    MEM_RD,
    MEM_WR,
    EXEC_ALU,
    WB,
    HALT
  } seq_state_t;

  // Opcode classes live in opcode1[7:4]; any value with bit 7 set is an ALU op.
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDM  = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [7:0] OP_HALT = 8'h7F;

  localparam logic [1:0] M2R_IMM = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_ALU = 2'b10;

endpackage

// File: rtl/cpu_sequencer_jump_cond_eval.sv
// rtl/cpu_sequencer_jump_cond_eval.sv - jump condition decode from opcode1[2:0] and flags
module jump_cond_eval (
  input  logic [2:0] cond,
  input  logic       carry_f,
  input  logic       zero_f,
  output logic       taken
);

  // cond[2] inverts the flag tests; cond[1:0]=00 is unconditional, 11 never jumps.
  always_comb begin
    taken = 1'b0;
    case (cond[1:0])
      2'b00:   taken = 1'b1;
      2'b01:   taken = carry_f ^ cond[2];
      2'b10:   taken = zero_f ^ cond[2];
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction fetch/decode/execute sequencer; CPU_SEQ_STEP_EN adds single-step
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter logic [7:0]  RESET_PC = 8'h00,
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [7:0] rom_data,
  input  logic       carry_in,
  input  logic       zero_in,
  input  logic       run,
`ifdef CPU_SEQ_STEP_EN
  input  logic       step,
`endif
  output logic [7:0] rom_address,
  output logic [7:0] opcode1,
  output logic [7:0] opcode2,
  output logic       n_cs,
  output logic       n_oe,
  output logic       n_we,
  output logic       reg_write,
  output logic       alu_op,
  output logic [2:0] alu_func,
  output logic [1:0] mem_to_reg,
  output logic       carry_f,
  output logic       zero_f,
  output logic       halted
);

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  seq_state_t state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] opcode1_q, opcode1_d;
  logic [7:0] opcode2_q, opcode2_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
  logic [1:0] m2r_q, m2r_d;
  logic [3:0] wait_q, wait_d;
  logic       jump_taken;
  logic       advance;
  seq_state_t next_fetch;

  jump_cond_eval u_jump_cond_eval (
    .cond    (opcode1_q[2:0]),
    .carry_f (carry_q),
    .zero_f  (zero_q),
    .taken   (jump_taken)
  );

`ifdef CPU_SEQ_STEP_EN
  assign advance = step;
`else
  assign advance = run;
`endif

  // Where every completed instruction goes next: fetch again or park in IDLE.
  assign next_fetch = advance ? FETCH1 : IDLE;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode1_d = opcode1_q;
    opcode2_d = opcode2_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    m2r_d     = m2r_q;
    wait_d    = wait_q;
    case (state_q)
      IDLE: if (advance) state_d = FETCH1;
      FETCH1: begin
        opcode1_d = rom_data;
        pc_d      = pc_q + 8'd1;
        state_d   = FETCH2;
      end
      FETCH2: begin
        opcode2_d = rom_data;
        pc_d      = pc_q + 8'd1;
        state_d   = DECODE;
      end
      DECODE: begin
        if (opcode1_q == OP_HALT) begin
          state_d = HALT;
        end else if (opcode1_q[7]) begin
          state_d = EXEC_ALU;
        end else begin
          case (opcode1_q[7:4])
            OP_LDI: begin
              state_d = WB;
              m2r_d   = M2R_IMM;
            end
            OP_LDM: state_d = MEM_RD;
            OP_ST:  state_d = MEM_WR;
            OP_JMP: begin
              if (jump_taken) pc_d = opcode2_q;
              state_d = next_fetch;
            end
            default: state_d = next_fetch;
          endcase
        end
      end
      MEM_RD: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = 4'd0;
          m2r_d   = M2R_MEM;
          state_d = WB;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      MEM_WR: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = 4'd0;
          state_d = next_fetch;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      EXEC_ALU: begin
        carry_d = carry_in;
        zero_d  = zero_in;
        m2r_d   = M2R_ALU;
        state_d = WB;
      end
      WB:      state_d = next_fetch;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      opcode1_q <= 8'h00;
      opcode2_q <= 8'h00;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      m2r_q     <= M2R_IMM;
      wait_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      opcode1_q <= opcode1_d;
      opcode2_q <= opcode2_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      m2r_q     <= m2r_d;
      wait_q    <= wait_d;
    end
  end

  // Strobes decode straight from state so reset releases them without a clock.
  assign n_cs        = !((state_q == MEM_RD) || (state_q == MEM_WR));
  assign n_oe        = (state_q != MEM_RD);
  assign n_we        = (state_q != MEM_WR);
  assign reg_write   = (state_q == WB);
  assign alu_op      = (state_q == EXEC_ALU);
  assign alu_func    = alu_op ? opcode1_q[6:4] : 3'b000;
  assign halted      = (state_q == HALT);
  assign rom_address = pc_q;
  assign opcode1     = opcode1_q;
  assign opcode2     = opcode2_q;
  assign mem_to_reg  = m2r_q;
  assign carry_f     = carry_q;
  assign zero_f      = zero_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer (MEM_WAIT=2)
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [7:0] rom_data;
  logic       carry_in, zero_in, run;
  logic [7:0] rom_address, opcode1, opcode2;
  logic       n_cs, n_oe, n_we, reg_write, alu_op;
  logic [2:0] alu_func;
  logic [1:0] mem_to_reg;
  logic       carry_f, zero_f, halted;

  logic [7:0] rom [0:255];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign rom_data = rom[rom_address];

  cpu_sequencer #(.RESET_PC(8'h00), .MEM_WAIT(2)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .rom_data    (rom_data),
    .carry_in    (carry_in),
    .zero_in     (zero_in),
    .run         (run),
    .rom_address (rom_address),
    .opcode1     (opcode1),
    .opcode2     (opcode2),
    .n_cs        (n_cs),
    .n_oe        (n_oe),
    .n_we        (n_we),
    .reg_write   (reg_write),
    .alu_op      (alu_op),
    .alu_func    (alu_func),
    .mem_to_reg  (mem_to_reg),
    .carry_f     (carry_f),
    .zero_f      (zero_f),
    .halted      (halted)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic apply_reset();
    n_reset = 1'b0;
    run     = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    carry_in = 1'b0;
    zero_in  = 1'b0;
    clear_rom();
    n_reset = 1'b0;
    run     = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({rom_address, opcode1, opcode2} !== 24'h000000) begin errors++; $display("FAIL reset_regs: got %h expected 000000", {rom_address, opcode1, opcode2}); end
    checks++; if ({n_cs, n_oe, n_we, reg_write, alu_op} !== 5'b11100) begin errors++; $display("FAIL reset_strobes: got %b expected 11100", {n_cs, n_oe, n_we, reg_write, alu_op}); end
    checks++; if ({alu_func, mem_to_reg, carry_f, zero_f, halted} !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000000", {alu_func, mem_to_reg, carry_f, zero_f, halted}); end
    n_reset = 1'b1;
    repeat (3) tick();
    checks++; if ({rom_address, n_cs} !== 9'h001) begin errors++; $display("FAIL idle_hold: got %h expected 001", {rom_address, n_cs}); end
  endtask

  task automatic test_load_imm();
    clear_rom();
    rom[0] = 8'h15; rom[1] = 8'h3C;
    apply_reset();
    run = 1'b1;
    tick();
    checks++; if ({rom_address, reg_write} !== 9'h000) begin errors++; $display("FAIL ldi_fetch1: got %h expected 000", {rom_address, reg_write}); end
    tick();
    checks++; if ({opcode1, rom_address} !== 16'h1501) begin errors++; $display("FAIL ldi_fetch2: got %h expected 1501", {opcode1, rom_address}); end
    tick();
    checks++; if ({opcode2, rom_address, reg_write} !== 17'h07804) begin errors++; $display("FAIL ldi_decode: got %h expected 07804", {opcode2, rom_address, reg_write}); end
    tick();
    checks++; if ({reg_write, mem_to_reg, rom_address} !== 11'h402) begin errors++; $display("FAIL ldi_wb: got %h expected 402", {reg_write, mem_to_reg, rom_address}); end
    tick();
    checks++; if ({reg_write, rom_address} !== 9'h002) begin errors++; $display("FAIL ldi_after_wb: got %h expected 002", {reg_write, rom_address}); end
  endtask

  task automatic test_load_mem();
    clear_rom();
    rom[0] = 8'h22; rom[1] = 8'h40;
    apply_reset();
    run = 1'b1;
    repeat (3) tick();
    checks++; if ({n_cs, n_oe, n_we} !== 3'b111) begin errors++; $display("FAIL ldm_decode_strobes: got %b expected 111", {n_cs, n_oe, n_we}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({n_cs, n_oe, n_we, reg_write} !== 4'b0010) begin errors++; $display("FAIL ldm_rd_cycle%0d: got %b expected 0010", c, {n_cs, n_oe, n_we, reg_write}); end
    end
    tick();
    checks++; if ({n_cs, n_oe, n_we, reg_write, mem_to_reg} !== 6'b111101) begin errors++; $display("FAIL ldm_wb: got %b expected 111101", {n_cs, n_oe, n_we, reg_write, mem_to_reg}); end
    tick();
    checks++; if ({reg_write, rom_address} !== 9'h002) begin errors++; $display("FAIL ldm_next_fetch: got %h expected 002", {reg_write, rom_address}); end
  endtask

  task automatic test_store();
    clear_rom();
    rom[0] = 8'h30; rom[1] = 8'h55;
    apply_reset();
    run = 1'b1;
    repeat (3) tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if ({n_cs, n_oe, n_we, reg_write} !== 4'b0100) begin errors++; $display("FAIL st_wr_cycle%0d: got %b expected 0100", c, {n_cs, n_oe, n_we, reg_write}); end
    end
    tick();
    checks++; if ({n_cs, n_oe, n_we, reg_write, rom_address} !== 12'hE02) begin errors++; $display("FAIL st_exit: got %h expected e02", {n_cs, n_oe, n_we, reg_write, rom_address}); end
  endtask

  task automatic test_reset_mid_store();
    clear_rom();
    rom[0] = 8'h30; rom[1] = 8'h55;
    apply_reset();
    run = 1'b1;
    repeat (4) tick();
    checks++; if (n_we !== 1'b0) begin errors++; $display("FAIL rst_wr_precond: got %b expected 0", n_we); end
    #2 n_reset = 1'b0;
    #1;
    checks++; if ({n_cs, n_oe, n_we, reg_write, alu_op} !== 5'b11100) begin errors++; $display("FAIL rst_wr_async: got %b expected 11100", {n_cs, n_oe, n_we, reg_write, alu_op}); end
    checks++; if ({rom_address, opcode1, opcode2, mem_to_reg, halted} !== 27'h0) begin errors++; $display("FAIL rst_wr_regs: got %h expected 0", {rom_address, opcode1, opcode2, mem_to_reg, halted}); end
    run = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) tick();
    checks++; if ({n_cs, n_oe, n_we, rom_address} !== 11'h700) begin errors++; $display("FAIL rst_wr_quiet: got %h expected 700", {n_cs, n_oe, n_we, rom_address}); end
  endtask

  task automatic test_alu_jump();
    clear_rom();
    rom[8'h00] = 8'hA1; rom[8'h01] = 8'h00;
    rom[8'h02] = 8'h41; rom[8'h03] = 8'h20;
    rom[8'h20] = 8'h45; rom[8'h21] = 8'h30;
    rom[8'h22] = 8'h15; rom[8'h23] = 8'h3C;
    carry_in = 1'b1;
    zero_in  = 1'b0;
    apply_reset();
    run = 1'b1;
    repeat (4) tick();
    checks++; if ({alu_op, alu_func, carry_f, reg_write} !== 6'b101000) begin errors++; $display("FAIL alu_exec: got %b expected 101000", {alu_op, alu_func, carry_f, reg_write}); end
    tick();
    checks++; if ({carry_f, zero_f, alu_op, alu_func, reg_write, mem_to_reg} !== 9'b100000110) begin errors++; $display("FAIL alu_wb: got %b expected 100000110", {carry_f, zero_f, alu_op, alu_func, reg_write, mem_to_reg}); end
    carry_in = 1'b0;
    zero_in  = 1'b1;
    repeat (4) tick();
    checks++; if (rom_address !== 8'h20) begin errors++; $display("FAIL jump_taken_pc: got %h expected 20", rom_address); end
    checks++; if ({carry_f, zero_f} !== 2'b10) begin errors++; $display("FAIL flags_hold: got %b expected 10", {carry_f, zero_f}); end
    repeat (3) tick();
    checks++; if (rom_address !== 8'h22) begin errors++; $display("FAIL jump_not_taken_pc: got %h expected 22", rom_address); end
    repeat (3) tick();
    checks++; if ({reg_write, mem_to_reg, carry_f, zero_f} !== 5'b10010) begin errors++; $display("FAIL ldi_after_alu: got %b expected 10010", {reg_write, mem_to_reg, carry_f, zero_f}); end
  endtask

  task automatic test_wrap_run();
    clear_rom();
    rom[8'h00] = 8'h40; rom[8'h01] = 8'hFE;
    apply_reset();
    run = 1'b1;
    repeat (4) tick();
    checks++; if (rom_address !== 8'hFE) begin errors++; $display("FAIL wrap_fe: got %h expected fe", rom_address); end
    tick();
    checks++; if (rom_address !== 8'hFF) begin errors++; $display("FAIL wrap_ff: got %h expected ff", rom_address); end
    tick();
    checks++; if (rom_address !== 8'h00 || $isunknown({rom_address, opcode1, opcode2})) begin errors++; $display("FAIL wrap_00: got %h expected 00", rom_address); end
    run = 1'b0;
    repeat (2) tick();
    checks++; if ({rom_address, n_cs, reg_write} !== 10'h002) begin errors++; $display("FAIL run_low_idle: got %h expected 002", {rom_address, n_cs, reg_write}); end
    run = 1'b1;
    repeat (2) tick();
    checks++; if (rom_address !== 8'h01) begin errors++; $display("FAIL run_resume: got %h expected 01", rom_address); end
  endtask

  task automatic test_halt();
    clear_rom();
    rom[0] = 8'h7F; rom[1] = 8'h00;
    apply_reset();
    run = 1'b1;
    repeat (3) tick();
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL halt_decode: got %b expected 0", halted); end
    tick();
    checks++; if ({halted, rom_address} !== 9'h102) begin errors++; $display("FAIL halt_entry: got %h expected 102", {halted, rom_address}); end
    for (int i = 0; i < 4; i++) begin
      run = i[0];
      repeat (2) tick();
      checks++; if ({halted, rom_address, reg_write} !== 10'h204) begin errors++; $display("FAIL halt_stay%0d: got %h expected 204", i, {halted, rom_address, reg_write}); end
    end
    n_reset = 1'b0;
    #1;
    checks++; if ({halted, rom_address} !== 9'h000) begin errors++; $display("FAIL halt_reset: got %h expected 000", {halted, rom_address}); end
    run = 1'b0;
    @(negedge clk);
    n_reset = 1'b1;
    repeat (2) tick();
    checks++; if ({halted, rom_address} !== 9'h000) begin errors++; $display("FAIL halt_after_reset: got %h expected 000", {halted, rom_address}); end
  endtask

  initial begin
    n_reset  = 1'b0;
    run      = 1'b0;
    carry_in = 1'b0;
    zero_in  = 1'b0;
    test_reset();
    test_load_imm();
    test_load_mem();
    test_store();
    test_reset_mid_store();
    test_alu_jump();
    test_wrap_run();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 Parameter RESET_PC, default 8'h00: value loaded into pc on reset.
REQ-002 Parameter MEM_WAIT, default 0: extra RAM wait cycles (0..15) held in MEM_RD/MEM_WR.
REQ-003 clk  in  1  single system clock; all state changes on posedge.
REQ-004 n_reset  in  1  asynchronous, active-low reset.
REQ-005 rom_data  in  8  combinational ROM read data for rom_address.
REQ-006 carry_in, zero_in  in  1 each  ALU flag outputs, valid during EXEC_ALU.
REQ-007 run  in  1  level; 0 holds the sequencer in IDLE.
REQ-008 rom_address  out  8  ROM fetch address; equals pc.
REQ-009 opcode1, opcode2  out  8 each  instruction register bytes.
REQ-010 n_cs, n_oe, n_we  out  1 each  RAM strobes, active-low.
REQ-011 reg_write  out  1  one-cycle register-file write strobe.
REQ-012 alu_op  out  1; alu_func  out  3; mem_to_reg  out  2  datapath controls.
REQ-013 carry_f, zero_f  out  1 each  registered flags.
REQ-014 halted  out  1  high while in HALT.
REQ-015 step  in  1  single-step pulse (present only with CPU_SEQ_STEP_EN).

Function
REQ-016 States: IDLE, FETCH1, FETCH2, DECODE, MEM_RD, MEM_WR, EXEC_ALU, WB, HALT.
REQ-017 IDLE -> FETCH1 when run=1; otherwise stay.
REQ-018 FETCH1: opcode1 <= rom_data, pc <= pc+1 (8-bit wrap, 8'hFF -> 8'h00).
REQ-019 FETCH2: opcode2 <= rom_data, pc <= pc+1 with same wrap; -> DECODE.
REQ-020 DECODE on opcode1[7:4]: 0000 nop -> FETCH1; 0001 load-imm -> WB with mem_to_reg=00; 0010 load-mem -> MEM_RD; 0011 store -> MEM_WR; 0100 jump -> FETCH1; 1xxx -> EXEC_ALU; opcode1==8'h7F -> HALT; other codes are nops.
REQ-021 Jump: opcode1[2:0]=000 unconditional; [1:0]=01 carry_f ([2]=1 inverts); [1:0]=10 zero_f ([2]=1 inverts); [1:0]=11 never; taken loads pc <= opcode2 in DECODE.
REQ-022 MEM_RD: n_cs=0,n_oe=0,n_we=1 for MEM_WAIT+1 cycles (wait counter), then -> WB with mem_to_reg=01.
REQ-023 MEM_WR: n_cs=0,n_oe=1,n_we=0 for MEM_WAIT+1 cycles, then -> FETCH1; reg_write stays 0.
REQ-024 EXEC_ALU: alu_op=1, alu_func=opcode1[6:4]; carry_f<=carry_in, zero_f<=zero_in at exit; -> WB with mem_to_reg=10.
REQ-025 WB: reg_write=1 exactly one cycle, mem_to_reg held; -> FETCH1.
REQ-026 Flags change only at EXEC_ALU exit.
REQ-027 Outside REQ-022/023, n_cs=n_oe=n_we=1; outside WB, reg_write=0; outside EXEC_ALU, alu_op=0.
REQ-028 run deasserted mid-instruction: current instruction completes; IDLE entered instead of FETCH1.
REQ-029 HALT is exited only by reset.
REQ-030 Cycle counts: nop/jump/halt-entry 3; load-imm 4; ALU 5; load-mem 5+MEM_WAIT; store 4+MEM_WAIT.

Reset
REQ-031 n_reset low: state=IDLE, pc=RESET_PC, opcode1=opcode2=0, carry_f=zero_f=0, n_cs=n_oe=n_we=1, reg_write=0, alu_op=0, alu_func=0, mem_to_reg=0, halted=0, wait counter=0.
REQ-032 Reset mid-MEM_WR deasserts n_we asynchronously; no further strobes until run.

Configuration
REQ-033 CPU_SEQ_STEP_EN defined: step port exists; FETCH1 is entered from IDLE or WB/DECODE/MEM_WR only on a step pulse, giving one instruction per pulse regardless of run.
REQ-034 CPU_SEQ_STEP_EN undefined: no step port; free-running per REQ-017..REQ-030.

Structure
REQ-035 Package cpu_pkg holds seq_state_t enum, opcode-class constants (OP_NOP, OP_LDI, OP_LDM, OP_ST, OP_JMP, OP_HALT=8'h7F) and mem_to_reg encodings.
REQ-036 One sub-module, jump_cond_eval (combinational: opcode1[2:0], flags -> taken).

Verification
REQ-037 ROM {8'h15,8'h3C}: reg_write pulse 4th cycle after run, mem_to_reg=00, pc=2.
REQ-038 ROM {8'h22,8'h40}, MEM_WAIT=2: n_cs=n_oe=0 for 3 cycles, then WB with mem_to_reg=01.
REQ-039 ALU 8'h81 with carry_in=1, zero_in=0, then {8'h41,8'h20}: pc becomes 8'h20; with 8'h45 pc falls through.
REQ-040 pc=8'hFE fetch of nop: pc wraps to 8'h00, no X.
REQ-041 8'h7F fetched: halted=1 and stays through run toggles; n_reset low clears to IDLE, pc=RESET_PC.
REQ-042 n_reset asserted during MEM_WR: n_we=1 same cycle, all outputs per REQ-031.
